axis_wave_sched_v5: RTL

Parametrised waveform-command scheduler that sits between the waveform-push AXI-Stream and the signal-generator parameter-memory read side. It buffers pushed commands in a FIFO and dispatches them one at a time. Each command is routed to one of NCH output channels, and the next dispatch is held off by the command's wait field. It adds multi-channel fan-out, a configurable wait width, run/halt, flush and trigger-gated dispatch.

---
 rtl/axis_wave_sched_pkg.sv | 18 +
 rtl/axis_wave_sched_fifo.sv | 55 +++++
 rtl/axis_wave_sched_v5.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/axis_wave_sched_pkg.sv
// Shared definitions for the waveform-command scheduler: command word layout
// and the dispatch FSM state encoding.
package axis_wave_sched_pkg;

  localparam int QSEL_LSB      = 72;
  localparam int CTRL_LSB      = 64;
  localparam int WAIT_LSB      = 32;
  localparam int ADDR_LSB      = 0;
  localparam int CTRL_TRIG_BIT = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    TRIG  = 2'd2,
    WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/axis_wave_sched_fifo.sv
// Synchronous FIFO with occupancy count; depth is 2**AW, pointers wrap naturally.
module axis_wave_sched_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic [AW:0]  o_count,
  output logic         o_full,
  output logic         o_empty
);
  localparam int          DEPTH     = 2 ** AW;
  localparam logic [AW:0] DEPTH_CNT = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_count == DEPTH_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  // A full FIFO never takes a write, even when a pop happens in the same cycle.
  assign w_wr    = i_push & ~o_full & i_rst_n & ~i_flush;
  assign w_rd    = i_pop & ~o_empty & i_rst_n & ~i_flush;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/axis_wave_sched_v5.sv
// Waveform-command scheduler: queues pushed commands and dispatches them one at a
// time to one of NCH channels, spaced by each command's wait field.
module axis_wave_sched_v5
  import axis_wave_sched_pkg::*;
#(
  parameter int NQ   = 4,
  parameter int NMEM = 3,
  parameter int BT   = 16,
  parameter int NCH  = 4
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            s_axis_tvalid,
  output logic            s_axis_tready,
  input  logic [79:0]     s_axis_tdata,
  input  logic            run,
  input  logic            flush,
  input  logic            trig,
  output logic [NCH-1:0]  m_valid,
  output logic [NMEM-1:0] m_addr,
  output logic [6:0]      m_ctrl,
  output logic            busy,
  output logic [NQ:0]     fifo_cnt,
  output logic            err_qsel
);
  localparam int             CW     = 16 + BT + NMEM;
  localparam logic [7:0]     NCH_Q  = 8'(NCH);
  localparam logic [NCH-1:0] CH_ONE = {{(NCH-1){1'b0}}, 1'b1};

  state_t        r_state;
  state_t        w_state_nxt;
  logic [BT-1:0] r_cnt;
  logic [BT-1:0] w_cnt_nxt;
  logic [CW-1:0] r_cmd;
  logic [CW-1:0] w_entry;
  logic [CW-1:0] w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_can_pop;
  logic          w_fire;
  logic          w_err_set;
  logic          w_qsel_ok;
  logic [7:0]    w_qsel;
  logic [7:0]    w_ctrl;
  logic [BT-1:0] w_wait;
  logic [NMEM-1:0] w_addr;
  logic          w_unused_tdata;

  // Only the fields that matter are queued; wait/addr upper bits are dropped here.
  assign w_entry = {s_axis_tdata[QSEL_LSB +: 8], s_axis_tdata[CTRL_LSB +: 8],
                    s_axis_tdata[WAIT_LSB +: BT], s_axis_tdata[ADDR_LSB +: NMEM]};
  assign w_unused_tdata = ^s_axis_tdata;

  assign s_axis_tready = aresetn & ~flush & ~w_full;
  assign w_push        = s_axis_tvalid & s_axis_tready;
  assign w_can_pop     = run & ~w_empty;

  assign w_addr = r_cmd[NMEM-1:0];
  assign w_wait = r_cmd[NMEM +: BT];
  assign w_ctrl = r_cmd[NMEM+BT +: 8];
  assign w_qsel = r_cmd[NMEM+BT+8 +: 8];

  assign w_qsel_ok = (w_qsel < NCH_Q);
  assign w_err_set = (r_state == ISSUE) & ~w_qsel_ok;
  assign w_fire    = ((r_state == ISSUE) & w_qsel_ok & ~w_ctrl[CTRL_TRIG_BIT])
                   | ((r_state == TRIG) & trig);
  assign busy      = (r_state == WAIT) | (r_state == TRIG) | ~w_empty;

  axis_wave_sched_fifo #(
    .W  (CW),
    .AW (NQ)
  ) u_fifo (
    .i_clk   (aclk),
    .i_rst_n (aresetn),
    .i_flush (flush),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (fifo_cnt),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    if (w_fire) begin
      // A zero wait chains straight into the next pop for one strobe per cycle.
      w_cnt_nxt = w_wait;
      if (w_wait != '0) begin
        w_state_nxt = WAIT;
      end else if (w_can_pop) begin
        w_pop       = 1'b1;
        w_state_nxt = ISSUE;
      end else begin
        w_state_nxt = IDLE;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_can_pop) begin
            w_pop       = 1'b1;
            w_state_nxt = ISSUE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        ISSUE: begin
          if (w_err_set) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = TRIG;
          end
        end
        TRIG: begin
          w_state_nxt = TRIG;
        end
        WAIT: begin
          if (r_cnt <= BT'(1)) begin
            w_cnt_nxt = '0;
            if (w_can_pop) begin
              w_pop       = 1'b1;
              w_state_nxt = ISSUE;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_cnt_nxt   = r_cnt - BT'(1);
            w_state_nxt = WAIT;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_cmd    <= '0;
      m_valid  <= '0;
      m_addr   <= '0;
      m_ctrl   <= '0;
      err_qsel <= 1'b0;
    end else if (flush) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      m_valid  <= '0;
      err_qsel <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_pop) r_cmd <= w_head;
      m_valid <= w_fire ? (CH_ONE << w_qsel[2:0]) : '0;
      if (w_fire) begin
        m_addr <= w_addr;
        m_ctrl <= w_ctrl[6:0];
      end
      if (w_err_set) err_qsel <= 1'b1;
    end
  end

endmodule
